// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot ROM loader: FSM state encoding,
// default frame sync marker and header byte positions.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Position of each header byte after the sync marker
  localparam logic [1:0] HDR_ADDR_HI = 2'd0;
  localparam logic [1:0] HDR_ADDR_LO = 2'd1;
  localparam logic [1:0] HDR_LEN_HI  = 2'd2;
  localparam logic [1:0] HDR_LEN_LO  = 2'd3;

endpackage

// File: rtl/boot_rom_loader_if.sv
// Byte stream input and RAM write port of the boot ROM loader.
// master: the loader side; slave: the stream source / RAM side.
interface boot_rom_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/boot_loader_packer.sv
// Little-endian byte-to-word packer: the first byte of a word ends up in
// bits [7:0]. word_valid pulses combinationally with the 4th accepted byte;
// the assembled word is on o_word the following cycle.
module boot_loader_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // Byte counter and shift-in register (new byte enters at the top)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clr) begin
      r_cnt  <= 2'd0;
    end else if (i_en) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= {i_byte, r_word[31:8]};
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = i_en && (r_cnt == 2'd3);
endmodule

// File: rtl/boot_rom_loader.sv
// Framed byte stream to boot RAM loader. Frame: SYNC, ADDR_HI, ADDR_LO,
// LEN_HI, LEN_LO, LEN*4 data bytes [, CSUM]. Holds the CPU in reset until a
// frame completes cleanly.
// Optional feature: define BOOT_LOADER_CHECKSUM_EN to expect a trailing
// checksum byte (8-bit sum of ADDR_HI..CSUM must be zero).
// ADDR_W is assumed to be larger than 8.
module boot_rom_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_W    = 11,
  parameter int         DEPTH     = 2048,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  boot_rom_loader_if.master   bus,
  output logic                cpu_reset_req,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t            r_state,   w_state_nxt;
  logic [1:0]        r_hdr_idx, w_hdr_idx_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic [7:0]        r_len_hi,  w_len_hi_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [7:0]        r_sum,     w_sum_nxt;
  logic              r_busy,    w_busy_nxt;
  logic              r_done,    w_done_nxt;
  logic              r_error,   w_error_nxt;
  logic              r_cpu_rst, w_cpu_rst_nxt;
  logic              r_ready;

  logic              w_acc;
  logic [15:0]       w_len;
  logic              w_pk_en;
  logic              w_pk_clr;
  logic [31:0]       w_word;
  logic              w_word_valid;

  assign w_acc    = bus.in_valid && r_ready;
  assign w_len    = {r_len_hi, bus.in_data};
  assign w_pk_en  = (r_state == DATA) && w_acc;
  assign w_pk_clr = (r_state == IDLE);

  boot_loader_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_pk_clr),
    .i_en         (w_pk_en),
    .i_byte       (bus.in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hdr_idx <= 2'd0;
      r_addr    <= '0;
      r_len_hi  <= 8'd0;
      r_cnt     <= '0;
      r_sum     <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hdr_idx <= w_hdr_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_len_hi  <= w_len_hi_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sum     <= w_sum_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_cpu_rst <= w_cpu_rst_nxt;
      // Registered so it is low during reset, and low for the WRITE cycle
      r_ready   <= (w_state_nxt != WRITE);
    end
  end

  // Next-state and next-value logic for frame parsing
  always_comb begin
    w_state_nxt   = r_state;
    w_hdr_idx_nxt = r_hdr_idx;
    w_addr_nxt    = r_addr;
    w_len_hi_nxt  = r_len_hi;
    w_cnt_nxt     = r_cnt;
    w_sum_nxt     = r_sum;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;
    w_cpu_rst_nxt = r_cpu_rst;

    case (r_state)
      IDLE: begin
        if (w_acc && (bus.in_data == SYNC_BYTE)) begin
          w_state_nxt   = HDR;
          w_hdr_idx_nxt = HDR_ADDR_HI;
          w_sum_nxt     = 8'd0;
          w_done_nxt    = 1'b0;
          w_error_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
          w_cpu_rst_nxt = 1'b1;
        end
      end

      HDR: begin
        if (w_acc) begin
          w_sum_nxt     = r_sum + bus.in_data;
          w_hdr_idx_nxt = r_hdr_idx + 2'd1;
          case (r_hdr_idx)
            HDR_ADDR_HI: w_addr_nxt   = {bus.in_data[ADDR_W-9:0], 8'h00};
            HDR_ADDR_LO: w_addr_nxt   = {r_addr[ADDR_W-1:8], bus.in_data};
            HDR_LEN_HI:  w_len_hi_nxt = bus.in_data;
            default: begin
              if ((w_len == 16'd0) || (w_len > 16'(DEPTH))) begin
                w_state_nxt = IDLE;
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
              end else begin
                w_state_nxt = DATA;
                w_cnt_nxt   = w_len[CNT_W-1:0];
              end
            end
          endcase
        end
      end

      DATA: begin
        if (w_acc) begin
          w_sum_nxt = r_sum + bus.in_data;
          if (w_word_valid) w_state_nxt = WRITE;
        end
      end

      WRITE: begin
        // Address wraps at DEPTH, independent of ADDR_W arithmetic
        w_addr_nxt = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
        w_cnt_nxt  = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          w_state_nxt   = CSUM;
`else
          w_state_nxt   = IDLE;
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_cpu_rst_nxt = 1'b0;
`endif
        end else begin
          w_state_nxt = DATA;
        end
      end

      CSUM: begin
        if (w_acc) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          if (8'(r_sum + bus.in_data) == 8'd0) begin
            w_done_nxt    = 1'b1;
            w_cpu_rst_nxt = 1'b0;
          end else begin
            w_error_nxt   = 1'b1;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready       = r_ready;
  assign bus.mem_address    = r_addr;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_chipselect = (r_state == WRITE);
  assign bus.mem_write      = (r_state == WRITE);
  assign bus.mem_writedata  = w_word;
  assign bus.mem_clken      = 1'b1;

  assign cpu_reset_req = r_cpu_rst;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
endmodule

// File: tb/tb_boot_rom_loader.sv
// Self-checking bench for boot_rom_loader: directed frames plus random frames
// compared against a frame-level reference model (expected word writes and
// final status computed straight from the frame bytes).
module tb_boot_rom_loader;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_reset_req, busy, done, error;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  boot_rom_loader_if #(.ADDR_W(11)) bus ();

  boot_rom_loader #(.ADDR_W(11), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .cpu_reset_req (cpu_reset_req),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Capture every RAM write seen on the port
  logic [10:0] obs_a[$];
  logic [31:0] obs_d[$];
  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      obs_a.push_back(bus.mem_address);
      obs_d.push_back(bus.mem_writedata);
      chk("wr_cs_be", {bus.mem_chipselect, bus.mem_byteenable, bus.mem_clken}, 32'b1_1111_1);
    end
  end

  // Offer one byte from a negedge until accepted, optionally idle afterwards
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] start,
                           input logic [15:0] len, input bit incr,
                           input bit garbage, input bit corrupt, input bit gaps);
    logic [7:0]  hdr[$];
    logic [7:0]  dat[$];
    logic [10:0] ea[$];
    logic [31:0] ed[$];
    logic [7:0]  sum;
    logic [7:0]  b;
    bit          legal, ok;

    // Reference model: frame bytes -> expected writes and status
    legal = (len != 16'd0) && (int'(len) <= DEPTH);
    hdr = {start[15:8], start[7:0], len[15:8], len[7:0]};
    if (legal) begin
      for (int i = 0; i < int'(len) * 4; i++) begin
        if (incr) b = 8'(8'h11 + i);
        else if ($urandom_range(0, 3) == 0) b = 8'hA5;
        else b = 8'($urandom);
        dat.push_back(b);
      end
      for (int i = 0; i < int'(len); i++) begin
        ea.push_back(11'((int'(start) + i) % DEPTH));
        ed.push_back({dat[4*i+3], dat[4*i+2], dat[4*i+1], dat[4*i]});
      end
    end
    sum = 8'd0;
    foreach (hdr[i]) sum += hdr[i];
    foreach (dat[i]) sum += dat[i];
`ifdef BOOT_LOADER_CHECKSUM_EN
    ok = legal && !corrupt;
`else
    ok = legal;
`endif

    if (garbage) begin
      send_byte(8'h00, gaps);
      send_byte(8'hFF, gaps);
      send_byte(8'h3C, gaps);
    end
    send_byte(8'hA5, gaps);
    foreach (hdr[i]) send_byte(hdr[i], gaps);
    foreach (dat[i]) send_byte(dat[i], gaps);
`ifdef BOOT_LOADER_CHECKSUM_EN
    if (legal) send_byte(8'(8'd0 - sum) + 8'(corrupt), gaps);
`endif
    repeat (4) @(negedge clk);

    chk({tag, "_nwr"}, obs_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < obs_a.size(); i++) begin
      chk({tag, "_addr"}, obs_a[i], ea[i]);
      chk({tag, "_data"}, obs_d[i], ed[i]);
    end
    chk({tag, "_done"},  done,          ok);
    chk({tag, "_error"}, error,         !ok);
    chk({tag, "_cpurst"}, cpu_reset_req, !ok);
    chk({tag, "_busy"},  busy,          1'b0);
    obs_a.delete();
    obs_d.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.in_ready,       1'b0);
    chk({tag, "_wr"},    bus.mem_write,      1'b0);
    chk({tag, "_cs"},    bus.mem_chipselect, 1'b0);
    chk({tag, "_addr"},  bus.mem_address,    11'd0);
    chk({tag, "_wdata"}, bus.mem_writedata,  32'd0);
    chk({tag, "_busy"},  busy,               1'b0);
    chk({tag, "_done"},  done,               1'b0);
    chk({tag, "_error"}, error,              1'b0);
    chk({tag, "_cpurst"}, cpu_reset_req,     1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic frame, garbage preamble, address wrap, illegal lengths
    run_frame("t1", 16'h0010, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("t2", 16'h0020, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("t3", 16'h07FF, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("t4a", 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("t4b", 16'h0000, 16'h0801, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame, after the second data byte
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h12, 1'b0);
    chk("t5_busy_mid", busy, 1'b1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("t5");
    chk("t5_nwr", obs_a.size(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame("t5b", 16'h0010, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Checksum corruption and gapped stream (corruption ignored without checksum)
    run_frame("t6a", 16'h0100, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame("t6b", 16'h0104, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame("t6c", 16'h0200, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random frames
    for (int k = 0; k < 20; k++) begin
      logic [15:0] st, ln;
      st = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ln = 16'd0;
      else if ($urandom_range(0, 9) == 0) ln = 16'h0801 + 16'($urandom_range(0, 50));
      else ln = 16'($urandom_range(1, 6));
      run_frame("rnd", st, ln, 1'b0, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
